cond_branch_unit: RTL and testbench
===================================

Name: cond_branch_unit

Overview:
Downstream consumer of condition_test in the execute stage. It accepts one decoded Thumb branch (B<cond> imm8 or B imm11) per handshake and drives its condition code onto the condition_test cond input. It samples the returned pass bit, computes the target, and issues a one-cycle redirect plus a parameterised pipeline-flush window. It is busy (not ready) from acceptance until the flush window completes.

Parameters:
FLUSH_CYCLES, 2, cycles flush is held after a taken branch; legal 1..15
PC_W, 32, program-counter width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
br_valid  in  1  decode presents a branch
br_ready  out  1  unit can accept a branch
br_kind  in  1  0 = conditional (imm8), 1 = unconditional (imm11)
br_cond  in  4  condition field; ignored when br_kind=1
br_imm  in  11  offset; conditional uses [7:0]
br_pc  in  PC_W  address of the branch instruction
cond  out  4  to condition_test cond input
pass  in  1  from condition_test
redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc
redirect_pc  out  PC_W  branch target
flush  out  1  squash younger instructions
not_taken  out  1  one-cycle pulse: branch resolved not taken
br_fault  out  1  one-cycle pulse: cond=4'b1111 on a conditional branch
br_kill  in  1  synchronous abort from exception logic

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; flush counter=0; latched fields=0; cond=4'b1110. All pulse outputs and flush are 0; br_ready=0 while rst_n is low and 1 from the first cycle after release.
- States: IDLE, EVAL, FLUSH.
- IDLE:
  - br_ready=1 unless br_kill=1.
  - On br_valid & br_ready: latch br_kind, br_cond, br_imm, br_pc, then go to EVAL.
- cond is driven from the latched value.
  - If kind=1, cond=4'b1110 (AL).
  - In IDLE, cond holds the last latched value.
- EVAL (exactly 1 cycle), br_ready=0. pass is combinational from condition_test and is sampled this cycle.
  - br_kill=1: no pulses; go to IDLE.
  - kind=0 and cond=4'b1111: br_fault=1; no redirect; go to IDLE.
  - pass=1: redirect_valid=1, redirect_pc=target; load counter with FLUSH_CYCLES; go to FLUSH.
  - pass=0: not_taken=1; go to IDLE.
- FLUSH: flush=1 and br_ready=0. Counter decrements each cycle; go to IDLE on the cycle the counter reaches 1. br_kill=1 goes to IDLE next cycle and clears the counter.
- Target arithmetic:
  - kind=0: offset = sign-extend(imm[7:0]) << 1.
  - kind=1: offset = sign-extend(imm[10:0]) << 1.
  - target = (pc + 4 + offset) mod 2^PC_W, with bit 0 forced to 0. Wrap-around past 0 or all-ones is silent.
- redirect_pc holds the last target between pulses. Consumers qualify it with redirect_valid.
- Latency for a taken branch:
  - accept edge t; redirect at t+1;
  - flush t+2 .. t+1+FLUSH_CYCLES;
  - br_ready=1 at t+2+FLUSH_CYCLES.
- Latency for a not-taken branch: accept t; not_taken at t+1; br_ready=1 at t+2.
- No back-to-back acceptance: br_ready is 0 during EVAL.
- At most one of redirect_valid, not_taken, br_fault is high in any cycle.

Optional Feature:
BRANCH_STATS_EN.
- Defined: adds outputs taken_cnt[15:0] and not_taken_cnt[15:0].
  - taken_cnt increments on each redirect_valid pulse.
  - not_taken_cnt increments on each not_taken pulse.
  - Both wrap 16'hFFFF -> 0, are cleared by rst_n, and are unaffected by br_kill or br_fault.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Taken, Z flag set: pc=32'h0000_0100, kind=0, cond=EQ(0000), imm=8'h10, Z=1 -> redirect_valid at t+1 with redirect_pc=32'h0000_0124; flush high for 2 cycles; br_ready=1 at t+4.
- Not taken: same branch with Z=0 -> not_taken pulse at t+1; no flush; br_ready=1 at t+2.
- Backward and wrap:
  - pc=32'h0000_0000, kind=1, imm=11'h7FE -> redirect_pc=32'h0000_0000.
  - pc=32'hFFFF_FFFC, kind=0, cond=AL, imm=8'h00 -> redirect_pc=32'h0000_0000.
- Fault: kind=0, cond=4'b1111 -> br_fault pulse only; no redirect or not_taken; br_ready=1 at t+2.
- Kill:
  - br_kill=1 during EVAL of a taken GT branch (Z=0, N=V) -> no redirect, no flush, IDLE next cycle.
  - br_kill=1 in the first FLUSH cycle -> flush drops next cycle.
- Reset and stats:
  - rst_n low mid-FLUSH -> flush=0 and state IDLE immediately (asynchronous).
  - With BRANCH_STATS_EN, 3 taken + 2 not-taken branches -> taken_cnt=3, not_taken_cnt=2; reset clears both to 0.

Source files
------------

// File: rtl/cond_branch_unit.sv
// Thumb branch resolver: drives cond to condition_test, issues redirect/not_taken/fault pulses and a flush window.
// Optional BRANCH_STATS_EN adds taken_cnt / not_taken_cnt counters.
module cond_branch_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_W         = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic            br_kind,
  input  logic [3:0]      br_cond,
  input  logic [10:0]     br_imm,
  input  logic [PC_W-1:0] br_pc,
  output logic [3:0]      cond,
  input  logic            pass,
  output logic            redirect_valid,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush,
  output logic            not_taken,
  output logic            br_fault,
  input  logic            br_kill
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     taken_cnt,
  output logic [15:0]     not_taken_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EVAL  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            kind_q, kind_d;
  logic [3:0]      cond_q, cond_d;
  logic [10:0]     imm_q, imm_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rpc_q, rpc_d;
  logic [PC_W-1:0] offset;
  logic [PC_W-1:0] target;

  always_comb begin
    if (kind_q) offset = {{(PC_W-12){imm_q[10]}}, imm_q, 1'b0};
    else        offset = {{(PC_W-9){imm_q[7]}}, imm_q[7:0], 1'b0};
    target = pc_q + PC_W'(4) + offset;
    target[0] = 1'b0;
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    kind_d         = kind_q;
    cond_d         = cond_q;
    imm_d          = imm_q;
    pc_d           = pc_q;
    rpc_d          = rpc_q;
    br_ready       = 1'b0;
    redirect_valid = 1'b0;
    not_taken      = 1'b0;
    br_fault       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        br_ready = rst_n & ~br_kill;
        if (br_valid && br_ready) begin
          kind_d  = br_kind;
          // Unconditional branches present AL so condition_test always passes.
          cond_d  = br_kind ? 4'b1110 : br_cond;
          imm_d   = br_imm;
          pc_d    = br_pc;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (br_kill) begin
          state_d = ST_IDLE;
        end else if (!kind_q && cond_q == 4'b1111) begin
          br_fault = 1'b1;
          state_d  = ST_IDLE;
        end else if (pass) begin
          redirect_valid = 1'b1;
          rpc_d          = target;
          cnt_d          = 4'(FLUSH_CYCLES);
          state_d        = ST_FLUSH;
        end else begin
          not_taken = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (br_kill) begin
          cnt_d   = 4'd0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign flush       = (state_q == ST_FLUSH);
  assign cond        = cond_q;
  assign redirect_pc = redirect_valid ? target : rpc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      kind_q  <= 1'b0;
      cond_q  <= 4'b1110;
      imm_q   <= 11'd0;
      pc_q    <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kind_q  <= kind_d;
      cond_q  <= cond_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rpc_q   <= rpc_d;
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic [15:0] not_taken_cnt_q, not_taken_cnt_d;

  always_comb begin
    taken_cnt_d     = taken_cnt_q + (redirect_valid ? 16'd1 : 16'd0);
    not_taken_cnt_d = not_taken_cnt_q + (not_taken ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q     <= 16'd0;
      not_taken_cnt_q <= 16'd0;
    end else begin
      taken_cnt_q     <= taken_cnt_d;
      not_taken_cnt_q <= not_taken_cnt_d;
    end
  end

  assign taken_cnt     = taken_cnt_q;
  assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_cond_branch_unit.sv
// Scoreboard bench for cond_branch_unit with a behavioural condition_test model.
module tb_cond_branch_unit;
  localparam int FC   = 2;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            br_valid = 1'b0;
  logic            br_ready;
  logic            br_kind = 1'b0;
  logic [3:0]      br_cond = 4'd0;
  logic [10:0]     br_imm = 11'd0;
  logic [PC_W-1:0] br_pc = '0;
  logic [3:0]      cond;
  logic            pass;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            flush;
  logic            not_taken;
  logic            br_fault;
  logic            br_kill = 1'b0;
  logic [3:0]      nzcv = 4'd0;
`ifdef BRANCH_STATS_EN
  logic [15:0]     taken_cnt;
  logic [15:0]     not_taken_cnt;
`endif

  cond_branch_unit #(.FLUSH_CYCLES(FC), .PC_W(PC_W)) dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
    .br_kind(br_kind), .br_cond(br_cond), .br_imm(br_imm), .br_pc(br_pc),
    .cond(cond), .pass(pass), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .not_taken(not_taken),
    .br_fault(br_fault), .br_kill(br_kill)
`ifdef BRANCH_STATS_EN
    , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: cond_pass = z;
      4'h1: cond_pass = !z;
      4'h2: cond_pass = cy;
      4'h3: cond_pass = !cy;
      4'h4: cond_pass = n;
      4'h5: cond_pass = !n;
      4'h6: cond_pass = v;
      4'h7: cond_pass = !v;
      4'h8: cond_pass = cy && !z;
      4'h9: cond_pass = !cy || z;
      4'hA: cond_pass = (n == v);
      4'hB: cond_pass = (n != v);
      4'hC: cond_pass = !z && (n == v);
      4'hD: cond_pass = z || (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  assign pass = cond_pass(cond, nzcv);

  typedef struct packed {
    logic [1:0]  typ;   // 0 redirect, 1 not_taken, 2 fault
    logic [31:0] pc;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int exp_tk = 0;
  int exp_nt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per pulse, then measures the following flush run.
  int  fl_cnt = 0;
  int  cur_fl = 0;
  bit  measuring = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      measuring = 0;
    end else if (redirect_valid || not_taken || br_fault) begin
      exp_t e;
      logic [1:0] typ;
      chk("one_pulse", 32'($countones({redirect_valid, not_taken, br_fault})), 32'd1);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got rv=%b nt=%b flt=%b expected none", redirect_valid, not_taken, br_fault);
      end else begin
        e   = sb.pop_front();
        typ = redirect_valid ? 2'd0 : (not_taken ? 2'd1 : 2'd2);
        chk("pulse_type", 32'(typ), 32'(e.typ));
        if (redirect_valid) chk("redirect_pc", redirect_pc, e.pc);
        cur_fl    = int'(e.fl);
        fl_cnt    = 0;
        measuring = 1;
      end
    end else if (measuring) begin
      if (flush) fl_cnt++;
      else begin
        chk("flush_len", 32'(fl_cnt), 32'(cur_fl));
        measuring = 0;
      end
    end else if (flush) begin
      checks++;
      failures++;
      $display("FAIL unexpected_flush: got flush=1 expected 0 at %0t", $time);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!br_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!br_ready) chk("ready_timeout", 32'(br_ready), 32'd1);
  endtask

  task automatic send(input logic k, input logic [3:0] c, input logic [10:0] imm,
                      input logic [31:0] pc, input logic [3:0] f, input int etyp,
                      input logic [31:0] epc, input int efl, input int kill_at,
                      input int elat, input logic [3:0] econd);
    exp_t e;
    int   lat;
    bit   got;
    wait_ready();
    nzcv = f; br_kind = k; br_cond = c; br_imm = imm; br_pc = pc; br_valid = 1'b1;
    if (etyp != 3) begin
      e.typ = 2'(etyp); e.pc = epc; e.fl = 4'(efl);
      sb.push_back(e);
      if (etyp == 0) exp_tk++;
      if (etyp == 1) exp_nt++;
    end
    @(posedge clk); #1;
    br_valid = 1'b0;
    lat = 1;
    got = 0;
    while (!got && lat < 40) begin
      br_kill = (lat == kill_at);
      @(negedge clk);
      if (lat == 1) chk("cond_out", 32'(cond), 32'(econd));
      if (br_ready) got = 1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    br_kill = 1'b0;
    chk("ready_latency", 32'(lat), 32'(elat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_br_ready", 32'(br_ready), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_cond", 32'(cond), 32'hE);
    chk("rst_pulses", 32'({redirect_valid, not_taken, br_fault}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(br_ready), 32'd1);

    //    k     cond   imm      pc            nzcv     typ epc           fl kill lat econd
    send(1'b0, 4'h0, 11'h010, 32'h0000_0100, 4'b0100, 0, 32'h0000_0124, FC, 0, 2+FC, 4'h0);
    send(1'b0, 4'h0, 11'h010, 32'h0000_0100, 4'b0000, 1, 32'h0,         0,  0, 2,    4'h0);
    send(1'b1, 4'h3, 11'h7FE, 32'h0000_0000, 4'b0000, 0, 32'h0000_0000, FC, 0, 2+FC, 4'hE);
    send(1'b0, 4'hE, 11'h000, 32'hFFFF_FFFC, 4'b0000, 0, 32'h0000_0000, FC, 0, 2+FC, 4'hE);
    send(1'b0, 4'hF, 11'h010, 32'h0000_0200, 4'b0100, 2, 32'h0,         0,  0, 2,    4'hF);
    send(1'b0, 4'hC, 11'h005, 32'h0000_0400, 4'b0000, 3, 32'h0,         0,  1, 2,    4'hC);
    send(1'b0, 4'h0, 11'h008, 32'h0000_0500, 4'b0100, 0, 32'h0000_0514, 1,  2, 3,    4'h0);
    send(1'b1, 4'h0, 11'h3FF, 32'h0000_1000, 4'b0000, 0, 32'h0000_1802, FC, 0, 2+FC, 4'hE);
    send(1'b0, 4'h1, 11'h080, 32'h0000_0200, 4'b0000, 0, 32'h0000_0104, FC, 0, 2+FC, 4'h1);
    send(1'b0, 4'hA, 11'h020, 32'h0000_0600, 4'b1000, 1, 32'h0,         0,  0, 2,    4'hA);

`ifdef BRANCH_STATS_EN
    @(negedge clk);
    chk("taken_cnt", 32'(taken_cnt), 32'(exp_tk));
    chk("not_taken_cnt", 32'(not_taken_cnt), 32'(exp_nt));
`endif

    // Asynchronous reset landing in the first flush cycle.
    wait_ready();
    nzcv = 4'b0100; br_kind = 1'b0; br_cond = 4'h0; br_imm = 11'h004;
    br_pc = 32'h0000_0300; br_valid = 1'b1;
    begin
      exp_t e;
      e.typ = 2'd0; e.pc = 32'h0000_030C; e.fl = 4'd0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    br_valid = 1'b0;
    @(posedge clk); #1;
    chk("flush_before_rst", 32'(flush), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_flush", 32'(flush), 32'd0);
    chk("async_rst_ready", 32'(br_ready), 32'd0);
    chk("async_rst_cond", 32'(cond), 32'hE);
`ifdef BRANCH_STATS_EN
    chk("rst_taken_cnt", 32'(taken_cnt), 32'd0);
    chk("rst_not_taken_cnt", 32'(not_taken_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst2", 32'(br_ready), 32'd1);
    chk("flush_after_rst2", 32'(flush), 32'd0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
